// File: rtl/rx_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser.
// State encoding, default sync marker and checksum width.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h7E;
  localparam int         CHK_W             = 8;

  // Read index width; a one-entry buffer still needs a one-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-stream and payload read bus between the UART receiver side and the parser.
interface rx_frame_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int AW = rx_frame_pkg::addr_w(MAX_LEN);

  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic [AW-1:0] i_Rd_Addr;
  logic [7:0]    o_Rd_Data;
  logic          o_Frame_Valid;
  logic          o_Frame_Err;
  logic [7:0]    o_Frame_Len;
  logic          o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Rd_Addr,
    input  o_Rd_Data, o_Frame_Valid, o_Frame_Err, o_Frame_Len, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Rd_Addr,
    output o_Rd_Data, o_Frame_Valid, o_Frame_Err, o_Frame_Len, o_Busy
  );

endinterface

// File: rtl/rx_frame_parser_buffer.sv
// Payload buffer: MAX_LEN x 8 simple dual-port RAM, synchronous write,
// registered read. Contents survive reset; only the read register clears.
module rx_frame_buffer
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int AW      = addr_w(MAX_LEN)
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  input  logic          i_Wr_En,
  input  logic [AW-1:0] i_Wr_Addr,
  input  logic [7:0]    i_Wr_Data,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [7:0]    o_Rd_Data
);

  logic [7:0] mem [MAX_LEN];
  logic [7:0] rd_data_q;

  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // Read-before-write: a same-edge write is not visible until the next read.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem[i_Rd_Addr];
    end
  end

  assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/rx_frame_parser.sv
// Sync-hunting, length-prefixed frame collector with 8-bit additive checksum.
// Optional inter-byte timeout enabled by defining RX_FRAME_TIMEOUT_EN.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 4340,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input logic              i_Clock,
  input logic              i_Reset_n,
  rx_frame_parser_if.slave bus
);

  localparam int         AW        = addr_w(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic [CHK_W-1:0] sum_q, sum_d;
  logic [CHK_W-1:0] chk_sum;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       frame_len_q, frame_len_d;
  logic             busy_q, busy_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_data;

`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    frame_len_d = frame_len_q;
    wr_en       = 1'b0;
    wr_addr     = idx_q[AW-1:0];
    wr_data     = bus.i_Rx_Byte;
    chk_sum     = sum_q + bus.i_Rx_Byte;
`ifdef RX_FRAME_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    if (bus.i_Rx_DV) begin
`ifdef RX_FRAME_TIMEOUT_EN
      tmo_d = '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.i_Rx_Byte == SYNC_BYTE) begin
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (bus.i_Rx_Byte == 8'h00 || bus.i_Rx_Byte > MAX_LEN_B) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d   = bus.i_Rx_Byte;
            sum_d   = bus.i_Rx_Byte;
            idx_d   = 8'h00;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          wr_en = 1'b1;
          sum_d = chk_sum;
          idx_d = idx_q + 8'h01;
          if (idx_d == len_q) begin
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_sum == '0) begin
            valid_d     = 1'b1;
            frame_len_d = len_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef RX_FRAME_TIMEOUT_EN
    // Error is registered on the edge where the count reaches TIMEOUT_CLKS-1.
    else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CLKS - 2)) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= 8'h00;
      idx_q       <= 8'h00;
      sum_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_len_q <= 8'h00;
      busy_q      <= 1'b0;
`ifdef RX_FRAME_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_len_q <= frame_len_d;
      busy_q      <= busy_d;
`ifdef RX_FRAME_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  rx_frame_buffer #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buffer (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Wr_En   (wr_en),
    .i_Wr_Addr (wr_addr),
    .i_Wr_Data (wr_data),
    .i_Rd_Addr (bus.i_Rd_Addr),
    .o_Rd_Data (bus.o_Rd_Data)
  );

  assign bus.o_Frame_Valid = valid_q;
  assign bus.o_Frame_Err   = err_q;
  assign bus.o_Frame_Len   = frame_len_q;
  assign bus.o_Busy        = busy_q;

endmodule
